// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver. Synchronizes the asynchronous serial input,
//            deframes characters with mid-bit sampling and queues received
//            bytes in a first-word-fall-through FIFO with sticky error flags.
// Ports    : clk_i        - system clock
//            rst_n_i      - synchronous active-low reset
//            rx_i         - asynchronous serial input, idle high
//            rd_en_i      - pop FIFO head (ignored when empty)
//            clr_err_i    - clear both sticky error flags
//            data_o       - FIFO head byte (combinational, valid with valid_o)
//            valid_o      - FIFO non-empty
//            count_o      - number of queued bytes
//            overrun_o    - sticky: byte dropped because FIFO was full
//            frame_err_o  - sticky: stop bit sampled as 0
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int unsigned CLK_HZ = 100000000,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       rx_i,
  input  logic                       rd_en_i,
  input  logic                       clr_err_i,
  output logic [7:0]                 data_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       overrun_o,
  output logic                       frame_err_o
);

  // Clocks per bit; must be at least 4 so that the half-bit load is >= 1.
  localparam int unsigned CPB     = CLK_HZ / BAUD;
  localparam int unsigned CNT_W   = $clog2(CPB);
  localparam int unsigned IDX_W   = $clog2(DEPTH);
  localparam int unsigned PTR_W   = IDX_W + 1;
  localparam int unsigned CNT_O_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_WAIT_HI = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic               sync1_q, sync2_q;
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_O_W-1:0] count_q, count_d;
  logic               valid_q, valid_d;
  logic               overrun_q, overrun_d;
  logic               frame_err_q, frame_err_d;

  logic [7:0]         mem [DEPTH];

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic rx_s;
  logic cnt_zero;
  logic full;
  logic pop;
  logic push;
  logic set_overrun;
  logic set_frame_err;

  assign rx_s     = sync2_q;
  assign cnt_zero = (cnt_q == '0);
  assign full     = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                    (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
  assign pop      = rd_en_i && valid_q;

  // --------------------------------------------------------------------------
  // Receive FSM: next state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    push          = 1'b0;
    set_overrun   = 1'b0;
    set_frame_err = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = CNT_HALF;
        end
      end

      S_START: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (!rx_s) begin
          state_d   = S_DATA;
          cnt_d     = CNT_FULL;
          bit_idx_d = 3'd0;
        end else begin
          // Start bit vanished by mid-bit: treat as a glitch.
          state_d = S_IDLE;
        end
      end

      S_DATA: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          shift_d   = {rx_s, shift_q[7:1]};
          cnt_d     = CNT_FULL;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end
      end

      S_STOP: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (rx_s) begin
          // A simultaneous pop frees a slot even when full.
          if (!full || pop) begin
            push = 1'b1;
          end else begin
            set_overrun = 1'b1;
          end
          state_d = S_IDLE;
        end else begin
          set_frame_err = 1'b1;
          state_d       = S_WAIT_HI;
        end
      end

      S_WAIT_HI: begin
        // Wait out a line break so it is not read as repeated 0x00 bytes.
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_ONE;
        end
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FIFO pointers, occupancy and sticky flags
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = CNT_O_W'(wr_ptr_d - rd_ptr_d);
    valid_d = (wr_ptr_d != rd_ptr_d);

    // Setting takes priority over clearing on the same edge.
    overrun_d   = set_overrun   ? 1'b1 : (clr_err_i ? 1'b0 : overrun_q);
    frame_err_d = set_frame_err ? 1'b1 : (clr_err_i ? 1'b0 : frame_err_q);
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= rx_i;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  // FIFO storage is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_q[IDX_W-1:0]] <= shift_q;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign data_o      = mem[rd_ptr_q[IDX_W-1:0]];
  assign valid_o     = valid_q;
  assign count_o     = count_q;
  assign overrun_o   = overrun_q;
  assign frame_err_o = frame_err_q;

endmodule
`default_nettype wire
